gpu_clut_load_sequencer: RTL and testbench

//  Sequences CLUT (palette) loads from VRAM into the CLUT cache RAM. Takes a palette load request,

---
 rtl/gpu_clut_load_sequencer.sv | 130 +++++++++++++
 tb/tb_gpu_clut_load_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_clut_load_sequencer.sv
// CLUT palette load sequencer: one-entry tag check, then 1 or 16 packet reads from VRAM
// with each returned beat written straight into the CLUT cache.
module gpu_clut_load_sequencer #(
  parameter int PKT_WORDS = 8
) (
  input  logic        i_clk,
  input  logic        i_rstGPU,
  input  logic        i_loadReq,
  input  logic [14:0] i_clutAdr,
  input  logic        i_is8BPP,
  input  logic        i_invalidate,
  output logic        o_busy,
  output logic        o_loadDone,
  output logic        o_memReq,
  output logic [14:0] o_memAdr,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [31:0] i_memData,
  output logic        o_clutWrite,
  output logic [6:0]  o_clutWrAdr,
  output logic [31:0] o_clutWrData
);

  // state   | meaning
  // IDLE    | waiting for a load request, tag compared here
  // REQ     | packet read request held until the arbiter acks
  // DATA    | streaming packet beats into the CLUT cache
  // DONE    | palette resident; completion pulse follows on the next cycle
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [14:0] adr;
  logic        is8;
  logic [3:0]  pkt;
  logic [2:0]  beat;
  logic        tag_valid;
  logic        tag8;
  logic [14:0] tag_adr;
  logic        pending_inval;
  logic        done_q;

  logic        hit;
  logic        last_beat;
  logic        last_pkt;
  logic [5:0]  x_adr;

  // An 8bpp fill also covers a 4bpp request at the same position.
  assign hit       = tag_valid && !i_invalidate && (tag_adr == i_clutAdr) && (tag8 || !i_is8BPP);
  assign last_beat = (beat == 3'(PKT_WORDS - 1));
  assign last_pkt  = is8 ? (pkt == 4'd15) : (pkt == 4'd0);
  assign x_adr     = adr[5:0] + 6'(pkt);

  assign o_busy       = (state != ST_IDLE);
  assign o_loadDone   = done_q;
  assign o_memReq     = (state == ST_REQ);
  assign o_memAdr     = o_memReq ? {adr[14:6], x_adr} : 15'd0;
  assign o_clutWrite  = (state == ST_DATA) && i_memDataValid;
  assign o_clutWrAdr  = o_clutWrite ? {pkt, beat} : 7'd0;
  assign o_clutWrData = i_memData;

  always_ff @(posedge i_clk or posedge i_rstGPU) begin
    if (i_rstGPU) begin
      state         <= ST_IDLE;
      adr           <= 15'd0;
      is8           <= 1'b0;
      pkt           <= 4'd0;
      beat          <= 3'd0;
      tag_valid     <= 1'b0;
      tag8          <= 1'b0;
      tag_adr       <= 15'd0;
      pending_inval <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (i_invalidate) begin
        tag_valid <= 1'b0;
        if ((state == ST_REQ) || (state == ST_DATA))
          pending_inval <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_loadReq) begin
            adr <= i_clutAdr;
            is8 <= i_is8BPP;
            if (hit) begin
              state <= ST_DONE;
            end else begin
              tag_valid <= 1'b0;
              pkt       <= 4'd0;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_memAck) begin
            beat  <= 3'd0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_memDataValid) begin
            if (last_beat) begin
              if (last_pkt) begin
                // A flush seen at any point during the fill keeps the new tag invalid.
                tag_valid <= !(pending_inval || i_invalidate);
                tag8      <= is8;
                tag_adr   <= adr;
                state     <= ST_DONE;
              end else begin
                pkt   <= pkt + 4'd1;
                state <= ST_REQ;
              end
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        ST_DONE: begin
          pending_inval <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_clut_load_sequencer.sv
// Randomized bench for gpu_clut_load_sequencer: acts as requester and VRAM arbiter,
// and checks every cycle against a palette-tag / packet-list model.
module tb_gpu_clut_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [14:0] clut_adr = 15'd0;
  logic        is8 = 1'b0;
  logic        inval = 1'b0;
  logic        busy;
  logic        load_done;
  logic        mem_req;
  logic [14:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        clut_write;
  logic [6:0]  wr_adr;
  logic [31:0] wr_data;

  int tests = 0;
  int fails = 0;

  // palette tag model
  bit          m_valid = 1'b0;
  logic [14:0] m_adr = 15'd0;
  bit          m_8 = 1'b0;

  // expectations of the fill in progress
  logic [14:0] f_adr = 15'd0;
  int          f_npk = 0;
  int          f_req0 = 0;
  int          f_wr0 = 0;

  // observations, written only by the compare process
  int          req_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          ri = 0;
  int          wi = 0;
  logic [14:0] first_adr = 15'd0;
  logic [14:0] last_adr = 15'd0;
  logic [6:0]  last_wr = 7'd0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;

  gpu_clut_load_sequencer #(.PKT_WORDS(8)) dut (
    .i_clk          (clk),
    .i_rstGPU       (rst),
    .i_loadReq      (load_req),
    .i_clutAdr      (clut_adr),
    .i_is8BPP       (is8),
    .i_invalidate   (inval),
    .o_busy         (busy),
    .o_loadDone     (load_done),
    .o_memReq       (mem_req),
    .o_memAdr       (mem_adr),
    .i_memAck       (mem_ack),
    .i_memDataValid (data_valid),
    .i_memData      (mem_data),
    .o_clutWrite    (clut_write),
    .o_clutWrAdr    (wr_adr),
    .o_clutWrData   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet i of a palette sits i blocks to the right, wrapping within the same line.
  function automatic logic [14:0] exp_pkt_adr(input logic [14:0] a, input int i);
    int x;
    x = (int'(a[5:0]) + i) % 64;
    return {a[14:6], 6'(x)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      ri = req_cnt - f_req0;
      wi = wr_cnt - f_wr0;
      if (prev_req && !prev_ack) check("req_held", mem_req, 1);
      if (prev_req && prev_ack)  check("req_drop", mem_req, 0);
      if (mem_req) begin
        check("req_allowed", ri < f_npk, 1);
        check("mem_adr", mem_adr, exp_pkt_adr(f_adr, ri));
        if (ri == 0) first_adr = mem_adr;
        last_adr = mem_adr;
        if (mem_ack) req_cnt++;
      end
      check("write_strobe", clut_write, data_valid);
      if (data_valid) begin
        check("write_allowed", wi < f_npk * 8, 1);
        check("wr_adr", wr_adr, wi);
        check("wr_data", wr_data, mem_data);
        last_wr = wr_adr;
        wr_cnt++;
      end
      if (load_done) done_cnt++;
      prev_req = mem_req;
      prev_ack = mem_ack;
    end else begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end
  end

  task automatic do_load(input logic [14:0] adr, input bit b8, input int ack_max, input int gap_max,
                         input int inval_pkt, input bit inval_same, input int rst_pkt);
    bit hit;
    int npk, d, g, guard, done0;
    hit = m_valid && (m_adr == adr) && (m_8 || !b8) && !inval_same;
    npk = hit ? 0 : (b8 ? 16 : 1);
    @(posedge clk); #1;
    f_adr = adr; f_npk = npk; f_req0 = req_cnt; f_wr0 = wr_cnt; done0 = done_cnt;
    load_req = 1'b1; clut_adr = adr; is8 = b8; inval = inval_same;
    @(posedge clk); #1;
    load_req = 1'b0; inval = 1'b0;
    check("busy_after_req", busy, 1);
    check("req_latency", mem_req, !hit);
    check("done_early", load_done, 0);
    if (hit) begin
      @(posedge clk); #1;
      check("hit_latency", load_done, 1);
    end
    for (int p = 0; p < npk; p++) begin
      guard = 0;
      while (!mem_req && guard < 100) begin @(posedge clk); #1; guard++; end
      if (!mem_req) begin
        check("req_timeout", mem_req, 1);
        return;
      end
      d = $urandom_range(ack_max, 0);
      repeat (d) begin @(posedge clk); #1; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int b = 0; b < 8; b++) begin
        g = $urandom_range(gap_max, 0);
        repeat (g) begin @(posedge clk); #1; end
        data_valid = 1'b1;
        mem_data = $urandom;
        if (p == inval_pkt && b == 2) inval = 1'b1;
        if (p == rst_pkt && b == 4) begin
          #2 rst = 1'b1;
          #1;
          check("rst_busy", busy, 0);
          check("rst_mem_req", mem_req, 0);
          check("rst_mem_adr", mem_adr, 0);
          check("rst_write", clut_write, 0);
          check("rst_wr_adr", wr_adr, 0);
          check("rst_done", load_done, 0);
          data_valid = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst = 1'b0;
          m_valid = 1'b0;
          f_npk = 0;
          return;
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        inval = 1'b0;
      end
    end
    guard = 0;
    while (done_cnt == done0 && guard < 100) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    check("load_done_pulses", done_cnt - done0, 1);
    check("req_count", req_cnt - f_req0, npk);
    check("write_count", wr_cnt - f_wr0, npk * 8);
    check("idle_after", busy, 0);
    if (!hit) begin
      m_valid = (inval_pkt < 0);
      m_adr = adr;
      m_8 = b8;
    end
  endtask

  initial begin
    logic [14:0] pool [4];
    pool[0] = 15'h1234; pool[1] = 15'h017C; pool[2] = 15'h0040; pool[3] = 15'h7FFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", load_done, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_adr", mem_adr, 0);
    check("reset_write", clut_write, 0);
    check("reset_wr_adr", wr_adr, 0);
    rst = 1'b0;

    do_load(15'h1234, 1'b0, 0, 0, -1, 1'b0, -1);
    check("t1_first_adr", first_adr, 15'h1234);
    check("t1_last_wr", last_wr, 7'd7);

    do_load(15'h1234, 1'b0, 3, 1, -1, 1'b0, -1);
    do_load(15'h1234, 1'b1, 3, 1, -1, 1'b0, -1);
    check("t2_last_wr", last_wr, 7'd127);

    do_load({9'd5, 6'd60}, 1'b1, 2, 2, -1, 1'b0, -1);
    check("t3_first_adr", first_adr, 15'h017C);
    check("t3_last_adr", last_adr, 15'h014B);
    check("t3_last_wr", last_wr, 7'd127);
    do_load({9'd5, 6'd60}, 1'b0, 2, 2, -1, 1'b0, -1);

    for (int i = 0; i < 8; i++)
      do_load(pool[$urandom_range(3, 0)], 1'($urandom_range(1, 0)), 10, 3, -1, 1'b0, -1);

    do_load(15'h0AC0, 1'b1, 2, 1, 3, 1'b0, -1);
    do_load(15'h0AC0, 1'b1, 2, 1, -1, 1'b0, -1);
    do_load(15'h0AC0, 1'b0, 1, 1, -1, 1'b1, -1);
    do_load(15'h0AC0, 1'b0, 1, 1, -1, 1'b0, -1);

    do_load(15'h2222, 1'b1, 2, 1, -1, 1'b0, 2);
    do_load(15'h2222, 1'b1, 2, 1, -1, 1'b0, -1);
    do_load(15'h2222, 1'b0, 2, 1, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
